// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: NS main road, EW side road, pedestrian walk phase.
// Lamps, walk, ped_wait and phase are registered Moore decodes of the state register.
module traffic_intersection_ctrl #(
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALL_RED_A = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALL_RED_B = 3'd5,
    S_PED_WALK  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);

  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  localparam logic [6:0] L_NS_GREEN  = 7'b0011000;
  localparam logic [6:0] L_NS_YELLOW = 7'b0101000;
  localparam logic [6:0] L_ALL_RED   = 7'b1001000;
  localparam logic [6:0] L_EW_GREEN  = 7'b1000010;
  localparam logic [6:0] L_EW_YELLOW = 7'b1000100;
  localparam logic [6:0] L_WALK      = 7'b1001001;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_next_dir_ew;
  logic             w_next_dir_ew_next;
  logic             r_ped_pending;
  logic             w_ped_pending_next;
  logic [6:0]       r_lamps;
  logic [6:0]       w_lamps_next;
  logic [2:0]       r_phase;

  function automatic logic [6:0] lamps_of(input state_t s);
    case (s)
      S_NS_GREEN:  lamps_of = L_NS_GREEN;
      S_NS_YELLOW: lamps_of = L_NS_YELLOW;
      S_ALL_RED_A: lamps_of = L_ALL_RED;
      S_EW_GREEN:  lamps_of = L_EW_GREEN;
      S_EW_YELLOW: lamps_of = L_EW_YELLOW;
      S_ALL_RED_B: lamps_of = L_ALL_RED;
      S_PED_WALK:  lamps_of = L_WALK;
      default:     lamps_of = L_NS_GREEN;
    endcase
  endfunction

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt + 1'b1;
    w_next_dir_ew_next = r_next_dir_ew;
    case (r_state)
      S_NS_GREEN: begin
        // NS holds green with a saturated counter until demand shows up.
        if (r_cnt >= GREEN_LAST) begin
          w_cnt_next = GREEN_LAST;
          if (ew_sensor || r_ped_pending) w_state_next = S_NS_YELLOW;
        end
      end
      S_NS_YELLOW: if (r_cnt >= YELLOW_LAST) w_state_next = S_ALL_RED_A;
      S_ALL_RED_A: begin
        if (r_cnt >= ALLRED_LAST) begin
          if (r_ped_pending) begin
            w_state_next       = S_PED_WALK;
            w_next_dir_ew_next = 1'b1;
          end else begin
            w_state_next = S_EW_GREEN;
          end
        end
      end
      S_EW_GREEN:  if (r_cnt >= GREEN_LAST)  w_state_next = S_EW_YELLOW;
      S_EW_YELLOW: if (r_cnt >= YELLOW_LAST) w_state_next = S_ALL_RED_B;
      S_ALL_RED_B: begin
        if (r_cnt >= ALLRED_LAST) begin
          if (r_ped_pending) begin
            w_state_next       = S_PED_WALK;
            w_next_dir_ew_next = 1'b0;
          end else begin
            w_state_next = S_NS_GREEN;
          end
        end
      end
      S_PED_WALK: begin
        if (r_cnt >= WALK_LAST) w_state_next = r_next_dir_ew ? S_EW_GREEN : S_NS_GREEN;
      end
      default: w_state_next = S_NS_GREEN;
    endcase
    if (w_state_next != r_state) w_cnt_next = '0;
  end

  // Entering the walk serves the request, so the clear beats a same-edge set.
  always_comb begin
    w_ped_pending_next = r_ped_pending;
    if (r_state != S_PED_WALK && w_state_next == S_PED_WALK) begin
      w_ped_pending_next = 1'b0;
    end else if (ped_req && r_state != S_PED_WALK) begin
      w_ped_pending_next = 1'b1;
    end
  end

  assign w_lamps_next = lamps_of(w_state_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_NS_GREEN;
      r_cnt         <= '0;
      r_next_dir_ew <= 1'b1;
      r_ped_pending <= 1'b0;
      r_lamps       <= L_NS_GREEN;
      r_phase       <= 3'd0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_next_dir_ew <= w_next_dir_ew_next;
      r_ped_pending <= w_ped_pending_next;
      r_lamps       <= w_lamps_next;
      r_phase       <= w_state_next;
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} = r_lamps;
  assign ped_wait = r_ped_pending;
  assign phase    = r_phase;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl: countdown reference model feeding a scoreboard queue,
// directed phase tables from the test plan and randomized safety/timing monitors.
module tb_traffic_intersection_ctrl;

  localparam int G = 8, Y = 3, AR = 2, W = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ew_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait;
  logic [2:0] phase;

  traffic_intersection_ctrl dut (
    .clk(clk), .reset(reset), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: time-left countdown per phase.
  int m_ph, m_left, m_dir_ew, m_pend;
  logic [10:0] exp_q[$];

  function automatic int dur(input int ph);
    case (ph)
      0, 3:    dur = G;
      1, 4:    dur = Y;
      2, 5:    dur = AR;
      default: dur = W;
    endcase
  endfunction

  function automatic logic [6:0] lamp_of(input int ph);
    case (ph)
      0:       lamp_of = 7'b0011000;
      1:       lamp_of = 7'b0101000;
      3:       lamp_of = 7'b1000010;
      4:       lamp_of = 7'b1000100;
      6:       lamp_of = 7'b1001001;
      default: lamp_of = 7'b1001000;
    endcase
  endfunction

  function automatic logic [10:0] exp_word();
    exp_word = {3'(m_ph), lamp_of(m_ph), m_pend[0]};
  endfunction

  function automatic logic [10:0] dut_word();
    dut_word = {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_left = G; m_dir_ew = 1; m_pend = 0;
  endtask

  task automatic model_step(input bit ew, input bit ped);
    int nph;
    bit go;
    nph = m_ph;
    go  = 1'b0;
    if (m_left > 1) begin
      m_left--;
    end else begin
      case (m_ph)
        0: if (ew || m_pend != 0) begin nph = 1; go = 1'b1; end
        1: begin nph = 2; go = 1'b1; end
        2: begin go = 1'b1; if (m_pend != 0) begin nph = 6; m_dir_ew = 1; end else nph = 3; end
        3: begin nph = 4; go = 1'b1; end
        4: begin nph = 5; go = 1'b1; end
        5: begin go = 1'b1; if (m_pend != 0) begin nph = 6; m_dir_ew = 0; end else nph = 0; end
        default: begin go = 1'b1; nph = (m_dir_ew != 0) ? 3 : 0; end
      endcase
    end
    if (go && nph == 6) m_pend = 0;
    else if (ped && m_ph != 6) m_pend = 1;
    if (go) begin
      m_ph   = nph;
      m_left = dur(nph);
    end
  endtask

  task automatic step(input bit ew, input bit ped);
    ew_sensor = ew;
    ped_req   = ped;
    model_step(ew, ped);
    exp_q.push_back(exp_word());
    @(posedge clk);
    #1;
    cyc++;
    check("scoreboard", 32'(dut_word()), 32'(exp_q.pop_front()));
  endtask

  task automatic rst_step();
    reset = 1'b1; ew_sensor = 1'b0; ped_req = 1'b0;
    model_reset();
    exp_q.push_back(exp_word());
    @(posedge clk);
    #1;
    check("reset_state", 32'(dut_word()), 32'(exp_q.pop_front()));
    reset = 1'b0;
  endtask

  task automatic do_reset();
    rst_step();
    reset = 1'b1;
    rst_step();
    cyc = 0;
  endtask

  function automatic int t1_phase(input int k);
    if (k <= 7)       t1_phase = 0;
    else if (k <= 10) t1_phase = 1;
    else if (k <= 12) t1_phase = 2;
    else if (k <= 20) t1_phase = 3;
    else if (k <= 23) t1_phase = 4;
    else if (k <= 25) t1_phase = 5;
    else              t1_phase = 0;
  endfunction

  function automatic int t3_phase(input int k);
    if (k <= 7)       t3_phase = 0;
    else if (k <= 10) t3_phase = 1;
    else if (k <= 12) t3_phase = 2;
    else if (k <= 18) t3_phase = 6;
    else              t3_phase = 3;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int walks, prev_ph, run, age;
    bit outstanding, ew, ped;

    // Test 1: EW demand constant
    do_reset();
    check("t1_phase", 32'(phase), 32'(t1_phase(0)));
    check("t1_rst_ns_green", 32'(ns_green), 32'd1);
    check("t1_rst_ew_red", 32'(ew_red), 32'd1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      check("t1_phase", 32'(phase), 32'(t1_phase(cyc)));
      check("t1_walk", 32'(walk), 32'd0);
    end

    // Test 2: no demand holds NS green, then EW arrives at cycle 50
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      check("t2_hold", 32'(phase), 32'd0);
    end
    step(1'b1, 1'b0);
    check("t2_yellow", 32'(phase), 32'd1);

    // Test 3: single pedestrian pulse at cycle 2
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(1'b0, i == 2);
      check("t3_phase", 32'(phase), 32'(t3_phase(cyc)));
      check("t3_ped_wait", 32'(ped_wait), 32'(cyc >= 3 && cyc <= 12));
      check("t3_walk", 32'(walk), 32'(cyc >= 13 && cyc <= 18));
    end

    // Test 4: ped_req held high
    do_reset();
    walks = 0; prev_ph = 0; run = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1);
      if (phase == 3'd6) begin
        check("t4_wait_in_walk", 32'(ped_wait), 32'd0);
        if (prev_ph != 6) walks++;
        run = 0;
      end else if (prev_ph == 6 || run == 1) begin
        run++;
        if (run == 2) check("t4_rewait", 32'(ped_wait), 32'd1);
      end
      prev_ph = int'(phase);
    end
    check("t4_walk_count", 32'(walks), 32'd3);

    // Test 5: reset in EW_YELLOW with a request pending
    do_reset();
    for (int i = 0; i < 22; i++) step(1'b1, i == 15);
    check("t5_pre_phase", 32'(phase), 32'd4);
    check("t5_pre_wait", 32'(ped_wait), 32'd1);
    rst_step();
    check("t5_phase", 32'(phase), 32'd0);
    check("t5_ns_green", 32'(ns_green), 32'd1);
    check("t5_ew_red", 32'(ew_red), 32'd1);
    check("t5_ped_wait", 32'(ped_wait), 32'd0);

    // Test 6: randomized traffic with safety and timing monitors
    do_reset();
    prev_ph = 0; run = 1; outstanding = 1'b0; age = 0;
    for (int i = 0; i < 10000; i++) begin
      ew  = 1'($urandom_range(0, 1));
      ped = ($urandom_range(0, 19) == 0);
      if (ped && phase != 3'd6 && !outstanding) begin
        outstanding = 1'b1;
        age = 0;
      end
      step(ew, ped);
      if (outstanding) age++;
      check("ns_onehot", 32'($countones({ns_red, ns_yellow, ns_green})), 32'd1);
      check("ew_onehot", 32'($countones({ew_red, ew_yellow, ew_green})), 32'd1);
      check("conflict", 32'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 32'd0);
      check("walk_safe", 32'(walk & ~(ns_red & ew_red)), 32'd0);
      if (int'(phase) == prev_ph) begin
        run++;
      end else begin
        if (prev_ph == 1 || prev_ph == 4) check("yellow_len", 32'(run), 32'(Y));
        if (prev_ph == 2 || prev_ph == 5) check("allred_len", 32'(run), 32'(AR));
        if (phase == 3'd6 && outstanding) begin
          check("ped_latency", 32'(age <= 40), 32'd1);
          outstanding = 1'b0;
        end
        run = 1;
      end
      prev_ph = int'(phase);
    end
    if (outstanding) check("ped_final_age", 32'(age <= 40), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
